// File: rtl/transform_sequencer.sv
// Laplace-pair readout sequencer: latches a line, fetches LHS/RHS bases from the mapper,
// and interleaves reads of the shared packed-ASCII memory into paced character slots.
module transform_sequencer #(
  parameter int DIV_W     = 16,
  parameter int MAX_CHARS = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  line_in,
  input  logic [1:0]  div_sel,
  output logic [5:0]  line,
  input  logic [17:0] pointer_addr,
  output logic [8:0]  mem_addr,
  input  logic [15:0] mem_dout,
  output logic [7:0]  lhs,
  output logic [7:0]  rhs,
  output logic        char_stb,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(MAX_CHARS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_WAIT, S_RD_L, S_RD_R, S_EMIT, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic             start_q;
  logic             trigger;
  logic [DIV_W-1:0] presc, div_last;
  logic             presc_hit;
  logic [8:0]       lhs_ptr, rhs_ptr, addr_q;
  logic             lhs_sel, rhs_sel, rd_sel;
  logic             lhs_end, rhs_end;
  logic [CNT_W-1:0] lhs_cnt, rhs_cnt;
  logic [7:0]       lhs_hold, rhs_hold, rd_byte;
  logic             lhs_stop, rhs_stop, both_end;

  assign trigger = start & ~start_q;

  always_comb begin
    div_last = '0;
    case (div_sel)
      2'd0:    div_last = '0;
      2'd1:    div_last = DIV_W'(15);
      2'd2:    div_last = DIV_W'(255);
      default: div_last = DIV_W'(65535);
    endcase
  end

  assign presc_hit = (presc == div_last);

  // Memory is read combinationally, so the address follows the live pointer in its RD slot
  // and otherwise holds whatever it last presented (including for an ended stream).
  always_comb begin
    mem_addr = addr_q;
    if (state_q == S_RD_L && !lhs_end)
      mem_addr = lhs_ptr;
    else if (state_q == S_RD_R && !rhs_end)
      mem_addr = rhs_ptr;
  end

  assign rd_sel  = (state_q == S_RD_L) ? lhs_sel : rhs_sel;
  assign rd_byte = rd_sel ? mem_dout[7:0] : mem_dout[15:8];

  assign lhs_stop = (lhs_hold == 8'h00) || (lhs_cnt == CNT_LAST);
  assign rhs_stop = (rhs_hold == 8'h00) || (rhs_cnt == CNT_LAST);
  assign both_end = (lhs_end || lhs_stop) && (rhs_end || rhs_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (trigger) state_d = S_MAP;
      S_MAP:  state_d = S_WAIT;
      S_WAIT: if (presc_hit) state_d = S_RD_L;
      S_RD_L: state_d = S_RD_R;
      S_RD_R: state_d = S_EMIT;
      S_EMIT: state_d = both_end ? S_FIN : S_WAIT;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      line     <= '0;
      addr_q   <= '0;
      presc    <= '0;
      lhs_ptr  <= '0;
      rhs_ptr  <= '0;
      lhs_sel  <= 1'b0;
      rhs_sel  <= 1'b0;
      lhs_end  <= 1'b0;
      rhs_end  <= 1'b0;
      lhs_cnt  <= '0;
      rhs_cnt  <= '0;
      lhs_hold <= '0;
      rhs_hold <= '0;
      lhs      <= '0;
      rhs      <= '0;
      char_stb <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_q  <= start;
      addr_q   <= mem_addr;
      char_stb <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            line <= line_in;
            busy <= 1'b1;
          end
        end
        S_MAP: begin
          lhs_ptr <= pointer_addr[17:9];
          rhs_ptr <= pointer_addr[8:0];
          lhs_sel <= 1'b0;
          rhs_sel <= 1'b0;
          lhs_end <= 1'b0;
          rhs_end <= 1'b0;
          lhs_cnt <= '0;
          rhs_cnt <= '0;
          presc   <= '0;
        end
        S_WAIT: presc <= presc_hit ? '0 : presc + 1'b1;
        S_RD_L: if (!lhs_end) lhs_hold <= rd_byte;
        S_RD_R: begin
          // Outputs are loaded here so they and the strobe are valid throughout EMIT.
          if (!rhs_end) rhs_hold <= rd_byte;
          lhs      <= lhs_end ? 8'h00 : lhs_hold;
          rhs      <= rhs_end ? 8'h00 : rd_byte;
          char_stb <= 1'b1;
        end
        S_EMIT: begin
          if (!lhs_end) begin
            if (lhs_stop) lhs_end <= 1'b1;
            else begin
              lhs_cnt <= lhs_cnt + 1'b1;
              lhs_sel <= ~lhs_sel;
              if (lhs_sel) lhs_ptr <= lhs_ptr + 9'd1;
            end
          end
          if (!rhs_end) begin
            if (rhs_stop) rhs_end <= 1'b1;
            else begin
              rhs_cnt <= rhs_cnt + 1'b1;
              rhs_sel <= ~rhs_sel;
              if (rhs_sel) rhs_ptr <= rhs_ptr + 9'd1;
            end
          end
          if (both_end) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_transform_sequencer.sv
// Randomized self-checking bench for transform_sequencer; expected streams come from
// byte-addressed string reads over the bench's own memory and line-map arrays.
module tb_transform_sequencer;

  localparam int MAXC = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  line_in;
  logic [1:0]  div_sel;
  logic [5:0]  line;
  logic [17:0] pointer_addr;
  logic [8:0]  mem_addr;
  logic [15:0] mem_dout;
  logic [7:0]  lhs, rhs;
  logic        char_stb, busy, done;

  logic [15:0] mem [512];
  logic [17:0] lmap [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_dout     = mem[mem_addr];
  assign pointer_addr = lmap[line];

  transform_sequencer #(.DIV_W(16), .MAX_CHARS(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_in(line_in), .div_sel(div_sel),
    .line(line), .pointer_addr(pointer_addr), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .lhs(lhs), .rhs(rhs), .char_stb(char_stb), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Character i of a string starting at word base, viewed as a flat 1024-byte ring.
  function automatic logic [7:0] get_char(input logic [8:0] base, input int i);
    logic [9:0] ba;
    logic [15:0] w;
    ba = {base, 1'b0} + 10'(i);
    w  = mem[ba[9:1]];
    return ba[0] ? w[7:0] : w[15:8];
  endfunction

  // Number of slots a stream occupies: through its terminator, or capped at MAXC.
  function automatic int stream_len(input logic [8:0] base);
    for (int i = 0; i < MAXC; i++)
      if (get_char(base, i) == 8'h00) return i + 1;
    return MAXC;
  endfunction

  function automatic logic [7:0] rand_byte(input bit nonzero);
    if (!nonzero && $urandom_range(0, 7) == 0) return 8'h00;
    return 8'($urandom_range(1, 255));
  endfunction

  task automatic fill_mem(input bit nonzero);
    for (int i = 0; i < 512; i++) mem[i] = {rand_byte(nonzero), rand_byte(nonzero)};
  endtask

  task automatic run(input logic [5:0] ln, input logic [1:0] ds, input bit hold);
    int lenl, lenr, n, idx, last_k, budget, div;
    logic [8:0] bl, br;
    bit seen_done;
    bl = lmap[ln][17:9];
    br = lmap[ln][8:0];
    lenl = stream_len(bl);
    lenr = stream_len(br);
    n = (lenl > lenr) ? lenl : lenr;
    div = 1 << (4 * ds);
    budget = (n + 2) * (div + 3) + 20;
    @(negedge clk);
    line_in = ln;
    div_sel = ds;
    start   = 1'b1;
    idx = 0; last_k = 0; seen_done = 0;
    for (int k = 1; k <= budget && !seen_done; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_rise", busy, 1);
      if (char_stb) begin
        check("stb_time", k, 4 + div + idx * (div + 3));
        check("lhs", lhs, (idx < lenl) ? get_char(bl, idx) : 8'h00);
        check("rhs", rhs, (idx < lenr) ? get_char(br, idx) : 8'h00);
        idx++;
        last_k = k;
      end
      if (done) begin
        seen_done = 1;
        check("done_time", k, last_k + 1);
        check("n_stb", idx, n);
        check("busy_fall", busy, 0);
        check("line_kept", line, ln);
      end
      if (!hold) begin
        if (k == 1) start = 1'b0;
        if (k == 5) begin start = 1'b1; line_in = ln ^ 6'd1; end
        if (k == 6) begin start = 1'b0; line_in = ln; end
      end
    end
    if (!seen_done) check("timeout", 0, 1);
    start = hold;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("quiet", {busy, char_stb, done}, 0);
    end
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_line"}, line, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_lhs"}, lhs, 0);
    check({tag, "_rhs"}, rhs, 0);
    check({tag, "_stb"}, char_stb, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic basic_setup();
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    lmap[3]  = {9'h010, 9'h020};
    mem[16]  = {8'h31, 8'h00};
    mem[32]  = {8'h31, 8'h2f};
    mem[33]  = {8'h73, 8'h00};
  endtask

  initial begin
    bit spurious;
    start = 1'b0; line_in = '0; div_sel = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 64; i++) lmap[i] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    basic_setup();
    run(6'd3, 2'd0, 1'b0);
    run(6'd3, 2'd1, 1'b0);
    run(6'd3, 2'd0, 1'b1);

    // Reset during a slow WAIT after the first slot has been emitted.
    @(negedge clk);
    line_in = 6'd3; div_sel = 2'd2; start = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy || char_stb || done) spurious = 1;
    end
    check("post_rst_idle", spurious, 0);
    run(6'd3, 2'd0, 1'b0);

    // Empty strings sharing a base.
    lmap[9] = {9'h050, 9'h050};
    mem[9'h050] = 16'h0000;
    run(6'd9, 2'd0, 1'b0);

    // Wrap through 0x1FF -> 0x000 with no terminator on the RHS.
    fill_mem(1'b1);
    lmap[7] = {9'h100, 9'h1FF};
    mem[9'h100] = {8'h41, 8'h00};
    run(6'd7, 2'd0, 1'b0);

    // Random memory contents, lines and pacing.
    fill_mem(1'b0);
    for (int r = 0; r < 6; r++) begin
      logic [5:0] ln;
      ln = 6'($urandom_range(0, 50));
      lmap[ln] = 18'($urandom);
      run(ln, 2'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transform_sequencer.md
# transform_sequencer

Controller that sequences one Laplace-pair readout: it latches the requested line, fetches the LHS and RHS string base addresses from the line mapper, and time-multiplexes the single packed-ASCII character memory between the two streams. It paces output with a programmable prescaler and presents one LHS byte and one RHS byte per character slot. It sits between the top-level switch inputs and the `memory_chars` / `line_mapper` pair, driving the `uio_out` / `uo_out` byte buses.

## Interface

Parameters:
- `DIV_W`, 16, prescaler counter width; must be ≥16.
- `MAX_CHARS`, 255, per-stream character limit before forced termination.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request; rising edge is the trigger.
- `line_in` in 6: requested function id, 0–50.
- `div_sel` in 2: character pacing; 0→1, 1→16, 2→256, 3→65536 clocks.
- `line` out 6: latched line to the mapper.
- `pointer_addr` in 18: from the mapper; [17:9] = LHS base word, [8:0] = RHS base word.
- `mem_addr` out 9: word address to character memory (combinational read).
- `mem_dout` in 16: packed word; [15:8] = even char, [7:0] = odd char.
- `lhs` out 8: current LHS character.
- `rhs` out 8: current RHS character.
- `char_stb` out 1: one-cycle pulse when `lhs`/`rhs` update.
- `busy` out 1: high from trigger until return to IDLE.
- `done` out 1: one-cycle pulse when both streams have terminated.

## Operation

- Reset values: `line`=0, `mem_addr`=0, `lhs`=0, `rhs`=0, `char_stb`=0, `busy`=0, `done`=0, state IDLE, all pointers and counters 0, `start_q`=0.
- Trigger: `start & ~start_q`, with `start_q` registered every cycle. A held-high `start` does not retrigger. Edges while `busy` is high are ignored and are not queued.
- State IDLE:
  - On trigger: latch `line_in` into `line`, set `busy`, and go to MAP.
- State MAP (1 cycle; the mapper is combinational):
  - Load the LHS word pointer from `pointer_addr[17:9]` and the RHS word pointer from `pointer_addr[8:0]`.
  - Clear both byte-select bits, both end flags, both char counters, and the prescaler.
  - Go to WAIT.
- State WAIT:
  - Prescaler increments each cycle.
  - When it equals divisor−1, clear it and go to RD_L.
  - With `div_sel`=0, WAIT lasts exactly 1 cycle.
  - `div_sel` is sampled live every cycle.
- State RD_L:
  - `mem_addr` = LHS pointer.
  - Capture the selected byte into a holding register: byte-select 0 → [15:8], 1 → [7:0].
  - Go to RD_R.
- State RD_R: same as RD_L, using the RHS pointer and RHS holding register. Go to EMIT.
- State EMIT:
  - Drive `lhs` and `rhs` from the holding registers and pulse `char_stb`.
  - For each stream not yet ended:
    - If the captured byte is 0x00, or its char counter has reached `MAX_CHARS`−1, set its end flag.
    - Otherwise increment its char counter and advance it: toggle byte-select; when byte-select goes 1→0, increment the word pointer.
  - If both end flags are now set, go to FIN; else go to WAIT.
- An ended stream:
  - is not read, and its output byte is forced to 0x00 in every later EMIT;
  - keeps `mem_addr` unchanged during its RD slot.
- State FIN: pulse `done`, clear `busy`, go to IDLE. `lhs`/`rhs` hold their last values.
- Word pointer arithmetic is 9-bit and wraps 511→0.
- The `MAX_CHARS` limit guarantees termination even if the memory has no 0x00 terminator.
- Both base addresses equal is legal; the two streams read independently.

## Timing

- Trigger edge seen at cycle T (`start` sampled high, `start_q` low):
  - `busy` high from T+1;
  - MAP at T+1;
  - first WAIT at T+2.
- One character slot is divisor + 3 cycles (WAIT ×divisor, RD_L, RD_R, EMIT).
  - With `div_sel`=0, `char_stb` fires every 4 cycles; the first one fires at T+5.
- N emitted slots: `done` fires one cycle after the last EMIT; `busy` falls in that same cycle.
- Asynchronous reset mid-operation: every output returns to its reset value immediately. No `done` pulse is produced.
- A `start` edge in the same cycle as FIN is ignored. A new request needs an edge after `busy` is low.

## Test plan

- **Basic pair:** `div_sel`=0, line 3, LHS "1\0" at word 0x010, RHS "1/s\0" at word 0x020.
  - Expect `char_stb` pulses with (lhs,rhs) = ('1','1'), (0x00,'/'), (0x00,'s'), (0x00,0x00).
  - Expect `done` one cycle after the 4th strobe.
  - Expect strobe spacing of exactly 4 cycles.
- **Pacing:** `div_sel`=1, same line.
  - Strobe spacing of 19 cycles.
  - First strobe at T+20.
- **Start held/retrigger:** hold `start` high across two runs.
  - Exactly one run occurs.
  - A pulse on `start` while `busy` produces no second run and no change to `line`.
- **Wrap and limit:** RHS base 0x1FF with memory filled with nonzero bytes.
  - Reads go to 0x1FF, then 0x000.
  - RHS ends after 255 characters; `done` follows when LHS has also ended.
- **Reset mid-run:** assert `rst_n`=0 during WAIT with `div_sel`=2.
  - All outputs are 0 asynchronously.
  - After release, IDLE until a new `start` edge; no spurious `char_stb` or `done`.
- **Empty strings:** both bases point at 0x00.
  - One strobe with (0x00,0x00).
  - `done` on the next cycle.
